stopwatch_ctrl: RTL



---
 rtl/stopwatch_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear stopwatch with a 4-digit BCD count (SS.cc) advanced by a 10 ms prescaler tick.
// Optional lap-freeze of the displayed digits is compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_ss,
  input  logic       i_clr,
  input  logic       i_lap,
  output logic       o_run,
  output logic       o_lap,
  output logic       o_wrap,
  output logic [3:0] o_d3,
  output logic [3:0] o_d2,
  output logic [3:0] o_d1,
  output logic [3:0] o_d0
);

  // state | meaning
  // IDLE  | count and prescaler at zero, waiting for start
  // RUN   | prescaler advancing, count incremented on each tick
  // PAUSE | count and prescaler frozen; start resumes, clear returns to IDLE

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PSC_ONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] psc, psc_nxt;
  logic [3:0]    cnt_d3, cnt_d2, cnt_d1, cnt_d0;
  logic [3:0]    d3_nxt, d2_nxt, d1_nxt, d0_nxt;
  logic          tick;
  logic          wrap_nxt;
  logic          clr_all;

  always_comb begin
    state_nxt = state;
    psc_nxt   = psc;
    tick      = 1'b0;
    clr_all   = 1'b0;
    case (state)
      IDLE: begin
        psc_nxt = '0;
        if (i_ss) state_nxt = RUN;
      end
      RUN: begin
        tick    = (psc == PSC_LAST);
        psc_nxt = tick ? '0 : psc + PSC_ONE;
        if (i_ss) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (i_clr) begin
          state_nxt = IDLE;
          clr_all   = 1'b1;
        end else if (i_ss) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        clr_all   = 1'b1;
      end
    endcase
  end

  // BCD ripple: each digit only moves when every lower digit wraps.
  always_comb begin
    d3_nxt   = cnt_d3;
    d2_nxt   = cnt_d2;
    d1_nxt   = cnt_d1;
    d0_nxt   = cnt_d0;
    wrap_nxt = 1'b0;
    if (tick) begin
      if (cnt_d0 == 4'd9) begin
        d0_nxt = 4'd0;
        if (cnt_d1 == 4'd9) begin
          d1_nxt = 4'd0;
          if (cnt_d2 == 4'd9) begin
            d2_nxt = 4'd0;
            if (cnt_d3 >= 4'd5) begin
              d3_nxt   = 4'd0;
              wrap_nxt = 1'b1;
            end else begin
              d3_nxt = cnt_d3 + 4'd1;
            end
          end else begin
            d2_nxt = cnt_d2 + 4'd1;
          end
        end else begin
          d1_nxt = cnt_d1 + 4'd1;
        end
      end else begin
        d0_nxt = cnt_d0 + 4'd1;
      end
    end
    if (clr_all) begin
      d3_nxt = 4'd0;
      d2_nxt = 4'd0;
      d1_nxt = 4'd0;
      d0_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state  <= IDLE;
      psc    <= '0;
      cnt_d3 <= 4'd0;
      cnt_d2 <= 4'd0;
      cnt_d1 <= 4'd0;
      cnt_d0 <= 4'd0;
      o_run  <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      state  <= state_nxt;
      psc    <= clr_all ? '0 : psc_nxt;
      cnt_d3 <= d3_nxt;
      cnt_d2 <= d2_nxt;
      cnt_d1 <= d1_nxt;
      cnt_d0 <= d0_nxt;
      o_run  <= (state_nxt == RUN);
      o_wrap <= wrap_nxt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic       lap_q, lap_nxt;
  logic [3:0] disp_d3, disp_d2, disp_d1, disp_d0;

  always_comb begin
    lap_nxt = lap_q;
    if (lap_q) begin
      if (i_lap || clr_all) lap_nxt = 1'b0;
    end else if (i_lap && (state == RUN)) begin
      lap_nxt = 1'b1;
    end
  end

  // Display follows the next live count unless frozen, so it stays a register output.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      lap_q   <= 1'b0;
      disp_d3 <= 4'd0;
      disp_d2 <= 4'd0;
      disp_d1 <= 4'd0;
      disp_d0 <= 4'd0;
    end else begin
      lap_q <= lap_nxt;
      if (!lap_nxt) begin
        disp_d3 <= d3_nxt;
        disp_d2 <= d2_nxt;
        disp_d1 <= d1_nxt;
        disp_d0 <= d0_nxt;
      end
    end
  end

  assign o_lap = lap_q;
  assign o_d3  = disp_d3;
  assign o_d2  = disp_d2;
  assign o_d1  = disp_d1;
  assign o_d0  = disp_d0;
`else
  logic unused_lap;
  assign unused_lap = i_lap;
  assign o_lap      = 1'b0;
  assign o_d3       = cnt_d3;
  assign o_d2       = cnt_d2;
  assign o_d1       = cnt_d1;
  assign o_d0       = cnt_d0;
`endif

endmodule
